// File: rtl/flag_register.sv
// Condition-flag producer: derives Z/N/V from the EX result, holds them, forwards same-cycle updates,
// and counts in-flight flag writers so decode can stall a dependent branch.
module flag_register #(
  parameter int DW           = 16,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_ovfl,
  input  logic [3:0]    ex_opcode,
  input  logic          ex_valid,
  input  logic          stall,
  input  logic          flush,
  input  logic          dec_sets_flags,
  output logic          Z,
  output logic          N,
  output logic          V,
  output logic          Z_fwd,
  output logic          N_fwd,
  output logic          V_fwd,
  output logic          flags_pending,
  output logic [1:0]    pend_cnt
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_INFLIGHT);

  logic       z_raw, n_raw, v_raw;
  logic       upd_z, upd_nv;
  logic       commit, inc, dec;
  logic [1:0] cnt_next;

  assign z_raw = (alu_result == '0);
  assign n_raw = alu_result[DW-1];
  assign v_raw = alu_ovfl;

  // ADD/SUB write all three flags; logic/shift ops write only Z.
  always_comb begin
    upd_z  = 1'b0;
    upd_nv = 1'b0;
    case (ex_opcode)
      4'b0000, 4'b0001: begin
        upd_z  = 1'b1;
        upd_nv = 1'b1;
      end
      4'b0010, 4'b0100, 4'b0101, 4'b0110: upd_z = 1'b1;
      default: ;
    endcase
  end

  assign commit = ex_valid & ~stall;
  assign inc    = dec_sets_flags & ~stall & ~flush;
  assign dec    = commit & upd_z;

  assign Z_fwd = (ex_valid & upd_z)  ? z_raw : Z;
  assign N_fwd = (ex_valid & upd_nv) ? n_raw : N;
  assign V_fwd = (ex_valid & upd_nv) ? v_raw : V;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Z <= 1'b0;
      N <= 1'b0;
      V <= 1'b0;
    end else if (commit) begin
      if (upd_z)  Z <= z_raw;
      if (upd_nv) N <= n_raw;
      if (upd_nv) V <= v_raw;
    end
  end

  // Only the ID/EX writer is younger than EX, so a flush leaves nothing in flight.
  always_comb begin
    cnt_next = pend_cnt;
    if (flush)
      cnt_next = '0;
    else if (inc && !dec)
      cnt_next = (pend_cnt == MAX_CNT) ? pend_cnt : pend_cnt + 2'd1;
    else if (dec && !inc && pend_cnt != '0)
      cnt_next = pend_cnt - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_cnt <= '0;
    else     pend_cnt <= cnt_next;
  end

  assign flags_pending = (pend_cnt != '0);

  no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(dec && !inc && !flush && pend_cnt == '0));

endmodule

// File: doc/flag_register.md
Name: flag_register

Overview:
- Producer side of the condition-flag interface consumed by PC_Updater (Z, N, V inputs).
- Derives Z/N/V from the EX-stage ALU result and applies the ISA's per-opcode update masks.
- Holds the flags architecturally and forwards same-cycle flags to the branch logic.
- Tracks flag-writing instructions still in flight so decode can stall a dependent branch.

Parameters:
- DW, 16, ALU result width
- MAX_INFLIGHT, 2, maximum number of flag writers between decode and the EX writeback point

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- alu_result  input  DW  EX-stage ALU result
- alu_ovfl  input  1  EX-stage signed overflow from the adder
- ex_opcode  input  4  opcode of the instruction in EX
- ex_valid  input  1  EX holds a real (non-bubble) instruction
- stall  input  1  pipeline freeze; EX does not retire this cycle
- flush  input  1  squash younger instructions (branch taken)
- dec_sets_flags  input  1  decode is issuing a flag-writing instruction this cycle
- Z  output  1  registered zero flag
- N  output  1  registered negative flag
- V  output  1  registered overflow flag
- Z_fwd  output  1  zero flag with the current EX update applied
- N_fwd  output  1  negative flag with the current EX update applied
- V_fwd  output  1  overflow flag with the current EX update applied
- flags_pending  output  1  at least one flag writer is in flight
- pend_cnt  output  2  number of flag writers in flight

Behaviour:
- Reset (async, rst=1): Z=N=V=0, pend_cnt=0, flags_pending=0. Forward outputs equal the registered flags when ex_valid=0.
- Raw flags, combinational:
  - z_raw = (alu_result == 0)
  - n_raw = alu_result[DW-1]
  - v_raw = alu_ovfl
- Update mask by ex_opcode:
  - 0000 ADD, 0001 SUB: update N, Z, V.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: update Z only.
  - All other opcodes: no update.
- Commit condition: commit = ex_valid & ~stall. flush does not block the EX instruction; flush squashes only younger instructions.
- Write: on the rising edge with commit=1, each flag selected by the mask takes its raw value. Unmasked flags hold.
- Latency: registered flags change 1 cycle after commit. *_fwd outputs are combinational:
  - If ex_valid=1 and the flag is in the mask, *_fwd = raw value.
  - Otherwise *_fwd = the registered flag.
  - *_fwd ignores stall.
- In-flight counter, per cycle:
  - inc = dec_sets_flags & ~stall & ~flush
  - dec = commit & (opcode in the ADD/SUB/XOR/SLL/SRA/ROR set)
  - pend_cnt_next = pend_cnt + inc − dec
  - Simultaneous inc and dec: count unchanged.
- Counter on flush: pend_cnt is set to dec ? 0 : pend_cnt − (number of younger writers). The design has exactly one younger stage (ID/EX boundary), so on flush pend_cnt is cleared to 0, after any same-cycle commit.
- Counter saturation: pend_cnt saturates at MAX_INFLIGHT and at 0. Underflow attempts are ignored, and an assertion fires in simulation.
- flags_pending = (pend_cnt != 0).
- Reset mid-operation clears all state immediately, independent of clk.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 → Z=N=V=0, pend_cnt=0. The same values hold with ex_valid=0 for 3 cycles.
- SUB result 0x0000, ovfl=0 (ex_opcode=0001, ex_valid=1) → Z_fwd=1 in the same cycle; next edge Z=1, N=0, V=0. Then ADD result 0x8000, ovfl=1 → Z=0, N=1, V=1.
- Starting from Z=0, N=1, V=1, XOR result 0x0000 → Z=1, N=1, V=1 (N and V held). Then opcode 0111 with result 0x0000 → no flag change.
- stall=1 with ADD result 0x0000 in EX → Z unchanged at the edge while Z_fwd=1. Release stall → Z=1 on the following edge.
- dec_sets_flags=1 for 2 consecutive cycles with no commits → pend_cnt=2, flags_pending=1. Then one cycle with both inc and an ADD commit → pend_cnt stays 2. Then two commits with no inc → pend_cnt=0.
- pend_cnt=1 with a flush and no commit → pend_cnt=0. Assert rst asynchronously mid-cycle with Z=1, pend_cnt=2 → Z=0 and pend_cnt=0 before the next clk edge.
